// File: rtl/seg_display_if.sv
// Character word and decimal-point requests going in, multiplexed
// segment, anode and frame-marker signals coming out.
interface seg_display_if;
   logic [19:0] seg_data;
   logic [3:0]  dp_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   modport master (output seg_data, dp_in, input seg, dp, an, frame_tick);
   modport slave  (input seg_data, dp_in, output seg, dp, an, frame_tick);
endinterface

// File: rtl/seg_display_controller.sv
// 4-digit common-anode 7-segment scanner. It latches the character word once
// per frame, decodes it and blanks the anodes for a guard time at the start
// of each digit slot.
module seg_display_controller #(
   parameter int REFRESH_DIV = 100_000,
   parameter int GUARD       = 1_000
) (
   input logic          clk,
   input logic          reset,
   seg_display_if.slave bus
);
   localparam int CW = $clog2(REFRESH_DIV);

   logic [CW-1:0] cnt;
   logic [1:0]    dig;
   logic [19:0]   shadow;
   logic [3:0]    dp_sh;
   logic [6:0]    seg_q;
   logic          dp_q;
   logic [3:0]    an_q;
   logic          frame_tick_q;

   logic          slot_end;
   logic          frame_start;
   logic          in_guard;
   logic [4:0]    code;
   logic [6:0]    seg_dec;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;
   logic [3:0]    an_nxt;

   assign slot_end    = (cnt == CW'(REFRESH_DIV - 1));
   assign frame_start = (cnt == '0) && (dig == 2'd0);

   // A zero guard would turn the compare into an always-false unsigned test.
   generate
      if (GUARD == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (cnt < CW'(GUARD));
      end
   endgenerate

   always_comb begin
      code = shadow[4:0];
      case (dig)
         2'd0: code = shadow[4:0];
         2'd1: code = shadow[9:5];
         2'd2: code = shadow[14:10];
         2'd3: code = shadow[19:15];
         default: code = shadow[4:0];
      endcase
   end

   // Patterns are {g,f,e,d,c,b,a}, active-low.
   always_comb begin
      seg_dec = 7'h7F;
      case (code)
         5'd0:  seg_dec = 7'h40;
         5'd1:  seg_dec = 7'h79;
         5'd2:  seg_dec = 7'h24;
         5'd3:  seg_dec = 7'h30;
         5'd4:  seg_dec = 7'h19;
         5'd5:  seg_dec = 7'h12;
         5'd6:  seg_dec = 7'h02;
         5'd7:  seg_dec = 7'h78;
         5'd8:  seg_dec = 7'h00;
         5'd9:  seg_dec = 7'h10;
         5'd10: seg_dec = 7'h3F;
         5'd11: seg_dec = 7'h06;
         5'd12: seg_dec = 7'h2F;
         5'd13: seg_dec = 7'h47;
         5'd14: seg_dec = 7'h0C;
         5'd15: seg_dec = 7'h2B;
         5'd16: seg_dec = 7'h41;
         5'd17: seg_dec = 7'h23;
         5'd18: seg_dec = 7'h03;
         5'd19: seg_dec = 7'h21;
         5'd20: seg_dec = 7'h09;
         5'd21: seg_dec = 7'h07;
         default: seg_dec = 7'h7F;
      endcase
   end

   always_comb begin
      an_nxt  = 4'b1111;
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
      if (!in_guard) begin
         an_nxt  = ~(4'b0001 << dig);
         seg_nxt = seg_dec;
         dp_nxt  = ~dp_sh[dig];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         dig          <= 2'd0;
         shadow       <= {4{5'd31}};
         dp_sh        <= 4'b0000;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         an_q         <= 4'b1111;
         frame_tick_q <= 1'b0;
      end else begin
         if (frame_start) begin
            shadow <= bus.seg_data;
            dp_sh  <= bus.dp_in;
         end
         frame_tick_q <= frame_start;
         if (slot_end) begin
            cnt <= '0;
            dig <= dig + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
         seg_q <= seg_nxt;
         dp_q  <= dp_nxt;
         an_q  <= an_nxt;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = frame_tick_q;
endmodule
